// File: rtl/resultado_uart_tx_pkg.sv
// Shared types and constants for the result-to-ASCII UART streamer.
// State encodings are one-hot to match the neighbouring FSMs.
package resultado_uart_tx_pkg;

    typedef enum logic [4:0] {
        ST_IDLE = 5'b00001,
        ST_CONV = 5'b00010,
        ST_SEND = 5'b00100,
        ST_WAIT = 5'b01000,
        ST_DONE = 5'b10000
    } state_t;

    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_MINUS = 8'h2D;
    localparam logic [7:0] ASCII_CR    = 8'h0D;

    // ceil(w * log10(2)) in integer arithmetic: decimal digits of 2^w - 1.
    function automatic int min_digits(input int w);
        return (w * 30103 + 99999) / 100000;
    endfunction

endpackage

// File: rtl/resultado_uart_tx_if.sv
// Handshake bundle between the concatenator/UART TX and the ASCII streamer.
// slave is the streamer side; master is the side that drives it.
interface resultado_uart_tx_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] resultado;
    logic             done;
    logic             tx_done;
    logic [7:0]       tx_data;
    logic             tx_start;
    logic             busy;

    modport master (
        output resultado,
        output done,
        output tx_done,
        input  tx_data,
        input  tx_start,
        input  busy
    );

    modport slave (
        input  resultado,
        input  done,
        input  tx_done,
        output tx_data,
        output tx_start,
        output busy
    );
endinterface

// File: rtl/resultado_uart_tx_div10_serial.sv
// Serial restoring divide-by-10: one quotient bit per cycle after a load cycle.
// valid, quotient and rem are presented during the final shift cycle.
module div10_serial #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] quotient,
    output logic [3:0]       rem
);
    localparam int CNTW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] r_quo;
    logic [3:0]       r_rem;
    logic [CNTW-1:0]  r_cnt;
    logic             r_busy;

    logic [4:0]       w_trial;
    logic             w_bit;
    logic [3:0]       w_rem_next;
    logic [WIDTH-1:0] w_quo_next;

    // Partial remainder stays below 10, so the trial value fits in 5 bits.
    always_comb begin
        w_trial    = {r_rem, r_quo[WIDTH-1]};
        w_bit      = (w_trial >= 5'd10);
        w_rem_next = w_bit ? 4'(w_trial - 5'd10) : w_trial[3:0];
        w_quo_next = {r_quo[WIDTH-2:0], w_bit};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_quo  <= '0;
            r_rem  <= 4'd0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (start) begin
            r_quo  <= dividend;
            r_rem  <= 4'd0;
            r_cnt  <= '0;
            r_busy <= 1'b1;
        end else if (r_busy) begin
            r_quo <= w_quo_next;
            r_rem <= w_rem_next;
            r_cnt <= r_cnt + CNTW'(1);
            if (r_cnt == CNTW'(WIDTH - 1)) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign busy     = r_busy;
    assign valid    = r_busy && (r_cnt == CNTW'(WIDTH - 1));
    assign quotient = w_quo_next;
    assign rem      = w_rem_next;

endmodule

// File: rtl/resultado_uart_tx.sv
// Converts a signed result to decimal ASCII (sign, digits MSD first, terminator)
// and streams it byte by byte over a tx_start/tx_done handshake.
module resultado_uart_tx
    import resultado_uart_tx_pkg::*;
#(
    parameter int         WIDTH     = 32,
    parameter int         NDIG      = 10,
    parameter logic [7:0] TERM_CHAR = ASCII_CR,
    parameter bit         SEND_TERM = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    resultado_uart_tx_if.slave bus
);
    localparam int BW = $clog2(NDIG + 3);

    if (NDIG < min_digits(WIDTH)) begin : g_ndig_check
        $error("NDIG too small to hold every decimal digit of a WIDTH-bit magnitude");
    end

    state_t           r_state;
    state_t           w_state_next;
    logic             r_neg;
    logic [WIDTH-1:0] r_mag;
    logic             r_busy;
    logic [BW-1:0]    r_count;
    logic [BW-1:0]    r_idx;

    logic             w_accept;
    logic             w_push;
    logic             w_advance;
    logic             w_tx_start;
    logic             w_last_byte;
    logic [BW-1:0]    w_total;
    logic [BW-1:0]    w_pos;
    logic [BW-1:0]    w_sel;
    logic [7:0]       w_byte;
    logic [3:0]       w_digit [NDIG];

    logic             w_div_start;
    logic             w_div_busy;
    logic             w_div_valid;
    logic [WIDTH-1:0] w_div_quot;
    logic [3:0]       w_div_rem;

    div10_serial #(
        .WIDTH(WIDTH)
    ) u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (w_div_start),
        .dividend (r_mag),
        .busy     (w_div_busy),
        .valid    (w_div_valid),
        .quotient (w_div_quot),
        .rem      (w_div_rem)
    );

    // Digit buffer, written LSD first at index r_count.
    for (genvar gi = 0; gi < NDIG; gi++) begin : g_digit
        logic [3:0] r_val;
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_val <= 4'd0;
            end else if (w_push && (r_count == BW'(gi))) begin
                r_val <= w_div_rem;
            end
        end
        assign w_digit[gi] = r_val;
    end

    // Byte r_idx of the outgoing string: optional sign, digits MSD first, terminator.
    always_comb begin
        w_total     = BW'(r_neg) + r_count + BW'(SEND_TERM);
        w_last_byte = (r_idx == w_total - BW'(1));
        w_pos       = r_idx - BW'(r_neg);
        w_sel       = r_count - w_pos - BW'(1);
        w_byte      = TERM_CHAR;
        if (r_neg && (r_idx == '0)) begin
            w_byte = ASCII_MINUS;
        end else if (w_pos < r_count) begin
            w_byte = ASCII_0 + {4'd0, w_digit[w_sel]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_push       = 1'b0;
        w_advance    = 1'b0;
        w_tx_start   = 1'b0;
        w_div_start  = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (bus.done) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_CONV;
                end
            end
            ST_CONV: begin
                w_div_start = !w_div_busy;
                if (w_div_valid) begin
                    w_push = 1'b1;
                    if (w_div_quot == '0) begin
                        w_state_next = ST_SEND;
                    end
                end
            end
            ST_SEND: begin
                w_tx_start   = 1'b1;
                w_state_next = ST_WAIT;
            end
            ST_WAIT: begin
                // A tick coincident with tx_start lands in SEND and is never seen here.
                if (bus.tx_done) begin
                    if (w_last_byte) begin
                        w_state_next = ST_DONE;
                    end else begin
                        w_advance    = 1'b1;
                        w_state_next = ST_SEND;
                    end
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_neg   <= 1'b0;
            r_mag   <= '0;
            r_busy  <= 1'b0;
            r_count <= '0;
            r_idx   <= '0;
        end else begin
            if (w_accept) begin
                r_neg   <= bus.resultado[WIDTH-1];
                r_mag   <= bus.resultado[WIDTH-1] ? -bus.resultado : bus.resultado;
                r_busy  <= 1'b1;
                r_count <= '0;
                r_idx   <= '0;
            end
            if (w_push) begin
                r_mag   <= w_div_quot;
                r_count <= r_count + BW'(1);
            end
            if (w_advance) begin
                r_idx <= r_idx + BW'(1);
            end
            if ((w_state_next == ST_DONE) || (r_state == ST_DONE)) begin
                r_busy <= 1'b0;
            end
            if (r_state == ST_DONE) begin
                r_count <= '0;
            end
        end
    end

    assign bus.tx_start = w_tx_start;
    assign bus.busy     = r_busy;
    assign bus.tx_data  = ((r_state == ST_SEND) || (r_state == ST_WAIT)) ? w_byte : 8'h00;

endmodule

// File: tb/tb_resultado_uart_tx.sv
// Scoreboard bench: expected ASCII strings come from $sformatf on the stimulus value;
// a UART TX model answers each tx_start with tx_done 20 cycles later.
module tb_resultado_uart_tx;
    localparam int WIDTH = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    resultado_uart_tx_if #(.WIDTH(WIDTH)) bus ();

    resultado_uart_tx #(
        .WIDTH     (WIDTH),
        .NDIG      (10),
        .TERM_CHAR (8'h0D),
        .SEND_TERM (1'b1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic tx_done_m = 1'b0;
    logic tx_done_s = 1'b0;
    assign bus.tx_done = tx_done_m | tx_done_s;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_done_cyc = 0;
    int n_starts = 0;
    bit glitch_mode = 1'b0;
    logic [7:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every tx_start pops one expected byte.
    initial begin
        logic [7:0] exp_b;
        forever begin
            @(negedge clk);
            if (reset !== 1'b1 && bus.tx_start === 1'b1) begin
                n_starts++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL byte_extra: got tx_data=%02h, required no tx_start", bus.tx_data);
                end else begin
                    exp_b = exp_q.pop_front();
                    if (bus.tx_data !== exp_b) begin
                        errors++;
                        $display("FAIL byte: got tx_data=%02h, required %02h", bus.tx_data, exp_b);
                    end else begin
                        $display("byte %02h ok", bus.tx_data);
                    end
                end
            end
        end
    end

    // UART TX model: tx_done 20 cycles after tx_start, tx_data must hold meanwhile.
    initial begin
        logic [7:0] held;
        bit ok;
        bit aborted;
        forever begin
            @(negedge clk);
            tx_done_m = 1'b0;
            if (reset !== 1'b1 && bus.tx_start === 1'b1) begin
                held = bus.tx_data;
                ok = 1'b1;
                aborted = 1'b0;
                if (glitch_mode) tx_done_m = 1'b1;
                for (int k = 1; k <= 20; k++) begin
                    @(negedge clk);
                    tx_done_m = 1'b0;
                    if (reset === 1'b1) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (bus.tx_data !== held || bus.tx_start !== 1'b0) ok = 1'b0;
                    if (k == 20) begin
                        tx_done_m = 1'b1;
                        last_done_cyc = cyc;
                    end
                end
                if (!aborted) begin
                    checks++;
                    if (!ok) begin
                        errors++;
                        $display("FAIL tx_hold: tx_data/tx_start changed during byte %02h, required stable and no tx_start", held);
                    end
                end
            end
        end
    end

    task automatic issue(input logic [31:0] v);
        string s;
        s = $sformatf("%0d", $signed(v));
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
        exp_q.push_back(8'h0D);
        $display("issue resultado=%0d expecting %0d bytes", $signed(v), s.len() + 1);
        bus.resultado = v;
        bus.done = 1'b1;
        @(negedge clk);
        bus.done = 1'b0;
        bus.resultado = $urandom;
    endtask

    task automatic run_value(input logic [31:0] v, input bit inject, input bit glitch);
        string s;
        int nd;
        int c0;
        int k;
        s = $sformatf("%0d", $signed(v));
        nd = s.len() - (v[31] ? 1 : 0);
        glitch_mode = glitch;
        c0 = cyc;
        issue(v);
        k = 1;
        while (bus.tx_start !== 1'b1 && k < 2000) begin
            tx_done_s = (k == 5);
            @(negedge clk);
            k++;
        end
        tx_done_s = 1'b0;
        checks++;
        if (bus.tx_start !== 1'b1 || (cyc - c0) != 33 * nd + 1) begin
            errors++;
            $display("FAIL latency: got %0d cycles, required %0d", cyc - c0, 33 * nd + 1);
        end
        if (inject) begin
            bus.resultado = 32'd99;
            bus.done = 1'b1;
            @(negedge clk);
            bus.done = 1'b0;
        end
        k = 0;
        while (bus.busy !== 1'b0 && k < 5000) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (bus.busy !== 1'b0 || (cyc - last_done_cyc) != 1) begin
            errors++;
            $display("FAIL busy_drop: busy=%b %0d cycles after last tx_done, required 0 after 1", bus.busy, cyc - last_done_cyc);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL bytes_missing: got %0d unsent, required 0", exp_q.size());
            exp_q.delete();
        end
        glitch_mode = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int base;
        logic [31:0] v;
        reset = 1'b1;
        bus.done = 1'b0;
        bus.resultado = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.tx_data !== 8'h00 || bus.tx_start !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got data=%02h start=%b busy=%b, required 00 0 0", bus.tx_data, bus.tx_start, bus.busy);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);

        run_value(32'd1234, 1'b0, 1'b0);
        run_value(32'd0, 1'b0, 1'b0);
        run_value(-32'sd7, 1'b0, 1'b1);
        run_value(32'h8000_0000, 1'b0, 1'b0);
        run_value(32'd1234, 1'b1, 1'b0);
        run_value(32'h7FFF_FFFF, 1'b0, 1'b1);

        // Reset during the second byte of 5678 aborts the string.
        base = n_starts;
        issue(32'd5678);
        k = 0;
        while (n_starts < base + 2 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (n_starts < base + 2) begin
            errors++;
            $display("FAIL reset_wait: got %0d tx_start, required 2", n_starts - base);
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (bus.tx_start !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_abort: got start=%b busy=%b, required 0 0", bus.tx_start, bus.busy);
        end
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        run_value(32'd5, 1'b0, 1'b0);

        // done coinciding with reset is dropped.
        reset = 1'b1;
        bus.resultado = 32'd1234;
        bus.done = 1'b1;
        @(negedge clk);
        bus.done = 1'b0;
        reset = 1'b0;
        k = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.busy !== 1'b0) k++;
        end
        checks++;
        if (k != 0) begin
            errors++;
            $display("FAIL done_with_reset: busy high %0d cycles, required 0", k);
        end

        for (int i = 0; i < 14; i++) begin
            case ($urandom_range(0, 3))
                0: v = $urandom;
                1: v = $urandom_range(0, 999);
                2: v = -$urandom_range(1, 99999);
                default: v = (i % 2 == 0) ? 32'hFFFF_FFFF : 32'd1000000000;
            endcase
            run_value(v, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
